adder_pipe_eval: RTL and testbench
==================================

# adder_pipe_eval

Parametrised, pipelined successor to the team's fixed 4-bit gate-level adders. Each operand pair produces three results: the exact sum, a lower-part-OR (LOA) approximate sum with a run-time approximation depth, and their absolute error. The block carries a valid/ready handshake with backpressure and keeps running error statistics. It sits between the stimulus source and the scoreboard in the error-evaluation flow.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- SEG, 4, bits added per pipeline stage; STAGES = ceil(WIDTH/SEG)
- CNT_W, 16, width of the statistics counters
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts an operand pair this cycle
- in_a, in_b  in  WIDTH  operands (unsigned)
- in_k  in  $clog2(WIDTH+1)  LOA depth; values above WIDTH are treated as WIDTH
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH+1  approximate sum, carry-out in the MSB
- out_exact  out  WIDTH+1  exact sum
- out_err  out  WIDTH+1  |out_exact − out_sum|
- stat_clr  in  1  synchronous clear of the statistics
- stat_samples  out  CNT_W  number of results transferred
- stat_errs  out  CNT_W  number of transfers with out_err ≠ 0
- stat_max_err  out  WIDTH+1  largest out_err transferred

## Operation
- Exact path: ripple add of in_a + in_b, split into SEG-bit segments. Each segment's carry passes to the next stage's register.
- Approximate path (LOA, depth k):
  - bits i<k: s_i = a_i | b_i.
  - Carry into bit k: a_{k−1} & b_{k−1}; this carry is 0 when k = 0.
  - Bits ≥k: exact addition with that carry-in.
  - k = 0 gives an exact result; k = WIDTH gives an all-OR result with carry-out a_{W−1}&b_{W−1}.
- in_k is captured with its operands and travels down the pipe. Changing in_k per transfer is legal.
- Stage s handles bits [s·SEG, min((s+1)·SEG, WIDTH)) of both paths. The last segment may be narrower than SEG.
- out_err is computed in the final stage from the completed sums.
- Pipeline control:
  - Each stage has a valid bit.
  - Stage i loads when it is empty or when it is advancing. The last stage advances on out_ready; stage i<last advances when stage i+1 loads.
  - in_ready is stage 0's load condition. It is combinational from out_ready through the chain.
  - Bubbles collapse. Capacity is STAGES entries.
- Statistics update on each out_valid && out_ready:
  - samples +1;
  - errs +1 if out_err ≠ 0;
  - max_err = max(max_err, out_err).
  - Counters saturate at all-ones and do not wrap.
- stat_clr has priority. When it coincides with a transfer, all statistics become 0 and that transfer is not counted.
- stat_clr does not affect the pipeline.

## Timing
- Latency: STAGES cycles from the in_valid&&in_ready edge to out_valid (2 for the defaults).
- Throughput: one result per cycle while out_ready = 1.
- A result stays stable while out_valid && !out_ready.
- Reset (asynchronous assert, synchronous release): all stage valids 0, out_valid 0, out_sum/out_exact/out_err 0, all statistics 0, in_ready 1 once rst_n = 1.
- Reset mid-operation discards in-flight entries. No partial result is emitted.

## Structure
- Package adder_eval_pkg holds:
  - the function loa_mask(k, WIDTH), which returns the OR-region mask;
  - the stage payload struct (partial exact sum, partial approximate sum, two carries, k, remaining operand bits);
  - the STAGES computation.
- Sub-module adder_seg_stage: one SEG-wide segment of the exact and LOA paths plus its valid/load logic. It is instantiated STAGES times via generate.
- The top level handles handshake wiring, the error subtractor and the statistics.

## Test plan
- a=0x0F, b=0x01, k=0 -> out_sum=out_exact=0x010, out_err=0, out_valid two cycles after acceptance.
- a=0x0F, b=0x01, k=4 -> out_sum=0x00F, out_exact=0x010, out_err=1; stat_errs=1, stat_max_err=1.
- a=0xFF, b=0xFF, k=8 and k=15 (clamped) -> out_sum=0x1FF, out_exact=0x1FE, out_err=1 for both.
- Continuous input with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts; no loss or duplication after release; results in order.
- stat_clr asserted with a transfer after 10 samples -> all statistics 0 on the next cycle; CNT_W=4 with 20 transfers -> stat_samples saturates at 15.
- rst_n pulsed low with 2 entries in flight -> out_valid=0 immediately; no stale result after release; statistics 0.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for the pipelined exact/LOA adder evaluator.
package adder_eval_pkg;

  // Upper bounds for operand width and LOA depth width carried in the payload.
  localparam int MAX_W  = 32;
  localparam int MAX_KW = 6;

  // Per-stage payload: partial sums, ripple carries, depth and operands.
  typedef struct packed {
    logic [MAX_W-1:0]  exact;
    logic [MAX_W-1:0]  approx;
    logic              c_exact;
    logic              c_approx;
    logic [MAX_KW-1:0] k;
    logic [MAX_W-1:0]  a;
    logic [MAX_W-1:0]  b;
  } stage_payload_t;

  // Number of SEG-wide stages needed to cover WIDTH bits.
  function automatic int calc_stages(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // OR-region mask: bit i set when i < k (and i < width).
  function automatic logic [MAX_W:0] loa_mask(input logic [MAX_KW-1:0] k, input int width);
    logic [MAX_W:0] m;
    m = '0;
    for (int i = 0; i <= MAX_W; i++) begin
      if ((i < width) && (i < int'(k))) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline segment: bits [LO,HI) of the exact and LOA adders plus valid/load.
module adder_seg_stage
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LO    = 0,
  parameter int HI    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  input  logic           down_load,
  input  stage_payload_t up_data,
  output logic           load_s,
  output logic           valid_r,
  output stage_payload_t data_r
);

  stage_payload_t nxt_s;
  logic [MAX_W:0] mask_s;
  logic           ce_s;
  logic           ca_s;
  logic           unused_mask_s;

  // A stage takes new data when it is empty or its content moves on.
  assign load_s = !valid_r || down_load;

  // Only part of the mask falls in this segment.
  assign unused_mask_s = ^mask_s;

  // Ripple this segment of both adders; LOA bits below k are OR-ed.
  always_comb begin
    nxt_s  = up_data;
    mask_s = loa_mask(up_data.k, WIDTH);
    ce_s   = up_data.c_exact;
    ca_s   = up_data.c_approx;
    for (int i = LO; i < HI; i++) begin
      nxt_s.exact[i] = up_data.a[i] ^ up_data.b[i] ^ ce_s;
      ce_s = (up_data.a[i] & up_data.b[i]) | (up_data.a[i] & ce_s) | (up_data.b[i] & ce_s);
      if (mask_s[i]) begin
        nxt_s.approx[i] = up_data.a[i] | up_data.b[i];
        // Topmost OR bit generates the carry into bit k.
        if (!mask_s[i+1]) begin
          ca_s = up_data.a[i] & up_data.b[i];
        end else begin
          ca_s = 1'b0;
        end
      end else begin
        nxt_s.approx[i] = up_data.a[i] ^ up_data.b[i] ^ ca_s;
        ca_s = (up_data.a[i] & up_data.b[i]) | (up_data.a[i] & ca_s) | (up_data.b[i] & ca_s);
      end
    end
    nxt_s.c_exact  = ce_s;
    nxt_s.c_approx = ca_s;
  end

  // Stage valid bit and payload register; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load_s) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= nxt_s;
      end else begin
        data_r <= data_r;
      end
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule

// File: rtl/adder_pipe_eval.sv
// Pipelined exact + LOA approximate adder with error output and running statistics.
module adder_pipe_eval
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [$clog2(WIDTH+1)-1:0]   in_k,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH:0]               out_sum,
  output logic [WIDTH:0]               out_exact,
  output logic [WIDTH:0]               out_err,
  input  logic                         stat_clr,
  output logic [CNT_W-1:0]             stat_samples,
  output logic [CNT_W-1:0]             stat_errs,
  output logic [WIDTH:0]               stat_max_err
);

  localparam int STAGES = calc_stages(WIDTH, SEG);
  localparam int KW     = $clog2(WIDTH+1);

  stage_payload_t in_pay_s;
  stage_payload_t fin_s;
  logic [WIDTH:0] exact_s;
  logic [WIDTH:0] approx_s;
  logic [WIDTH:0] err_s;
  logic           fire_s;
  logic           unused_fin_s;
  logic [CNT_W-1:0] samples_r;
  logic [CNT_W-1:0] errs_r;
  logic [WIDTH:0]   max_err_r;

  // Build the stage-0 payload; depth beyond WIDTH is clamped to WIDTH.
  always_comb begin
    in_pay_s = '0;
    in_pay_s.a[WIDTH-1:0] = in_a;
    in_pay_s.b[WIDTH-1:0] = in_b;
    if (in_k > KW'(WIDTH)) begin
      in_pay_s.k = MAX_KW'(WIDTH);
    end else begin
      in_pay_s.k = MAX_KW'(in_k);
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SEG;
    localparam int HI = ((s + 1) * SEG > WIDTH) ? WIDTH : (s + 1) * SEG;
    logic           down_load_s;
    logic           up_valid_s;
    logic           load_s;
    logic           valid_r;
    stage_payload_t up_data_s;
    stage_payload_t data_r;

    if (s == STAGES - 1) begin : g_last
      assign down_load_s = out_ready;
    end else begin : g_mid
      assign down_load_s = g_stage[s+1].load_s;
    end

    if (s == 0) begin : g_first
      assign up_valid_s = in_valid;
      assign up_data_s  = in_pay_s;
    end else begin : g_next
      assign up_valid_s = g_stage[s-1].valid_r;
      assign up_data_s  = g_stage[s-1].data_r;
    end

    adder_seg_stage #(.WIDTH(WIDTH), .LO(LO), .HI(HI)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid  (up_valid_s),
      .down_load (down_load_s),
      .up_data   (up_data_s),
      .load_s    (load_s),
      .valid_r   (valid_r),
      .data_r    (data_r)
    );
  end

  assign in_ready  = g_stage[0].load_s;
  assign out_valid = g_stage[STAGES-1].valid_r;
  assign fin_s     = g_stage[STAGES-1].data_r;

  // Operands and upper payload bits are not needed past the last stage.
  assign unused_fin_s = ^fin_s;

  assign exact_s   = {fin_s.c_exact,  fin_s.exact[WIDTH-1:0]};
  assign approx_s  = {fin_s.c_approx, fin_s.approx[WIDTH-1:0]};
  assign out_sum   = approx_s;
  assign out_exact = exact_s;
  assign out_err   = err_s;
  assign fire_s    = out_valid && out_ready;

  // Absolute difference of the completed sums.
  always_comb begin
    if (exact_s >= approx_s) begin
      err_s = exact_s - approx_s;
    end else begin
      err_s = approx_s - exact_s;
    end
  end

  // Saturating statistics; a clear wins over a coinciding transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_r <= '0;
      errs_r    <= '0;
      max_err_r <= '0;
    end else if (stat_clr) begin
      samples_r <= '0;
      errs_r    <= '0;
      max_err_r <= '0;
    end else if (fire_s) begin
      if (samples_r != {CNT_W{1'b1}}) begin
        samples_r <= samples_r + CNT_W'(1);
      end else begin
        samples_r <= samples_r;
      end
      if ((err_s != '0) && (errs_r != {CNT_W{1'b1}})) begin
        errs_r <= errs_r + CNT_W'(1);
      end else begin
        errs_r <= errs_r;
      end
      if (err_s > max_err_r) begin
        max_err_r <= err_s;
      end else begin
        max_err_r <= max_err_r;
      end
    end else begin
      samples_r <= samples_r;
      errs_r    <= errs_r;
      max_err_r <= max_err_r;
    end
  end

  assign stat_samples = samples_r;
  assign stat_errs    = errs_r;
  assign stat_max_err = max_err_r;

endmodule

// File: tb/tb_adder_pipe_eval.sv
// Scoreboard bench for adder_pipe_eval (WIDTH=8, SEG=4, CNT_W=4).
module tb_adder_pipe_eval;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] k;
    logic [8:0] sum;
    logic [8:0] exact;
    logic [8:0] err;
  } vec_t;

  typedef struct {
    logic [8:0] sum;
    logic [8:0] exact;
    logic [8:0] err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_k;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic [8:0] out_exact;
  logic [8:0] out_err;
  logic       stat_clr;
  logic [3:0] stat_samples;
  logic [3:0] stat_errs;
  logic [8:0] stat_max_err;

  int   vectors;
  int   miscompares;
  vec_t vt [10];
  exp_t exp_q [$];
  int   m_samples;
  int   m_errs;
  int   m_max;

  adder_pipe_eval #(.WIDTH(8), .SEG(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_k         (in_k),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_exact    (out_exact),
    .out_err      (out_err),
    .stat_clr     (stat_clr),
    .stat_samples (stat_samples),
    .stat_errs    (stat_errs),
    .stat_max_err (stat_max_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic drive(input int j);
    in_valid = 1'b1;
    in_a = vt[j].a;
    in_b = vt[j].b;
    in_k = vt[j].k;
  endtask

  task automatic push(input int j);
    exp_t e;
    e.sum = vt[j].sum;
    e.exact = vt[j].exact;
    e.err = vt[j].err;
    exp_q.push_back(e);
  endtask

  // Present vector j until accepted; returns #1 after the accepting edge.
  task automatic send(input int j);
    logic acc;
    int   budget;
    budget = 0;
    drive(j);
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      budget++;
      if (budget > 50) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    if (acc) push(j);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_samples"}, 32'(stat_samples), 32'(m_samples));
    check({tag, "_errs"},    32'(stat_errs),    32'(m_errs));
    check({tag, "_max_err"}, 32'(stat_max_err), 32'(m_max));
  endtask

  // Monitor: compare presented results with the queue head, pop on transfer.
  initial begin
    exp_t e;
    m_samples = 0;
    m_errs = 0;
    m_max = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_samples = 0;
        m_errs = 0;
        m_max = 0;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            check("out_sum",   32'(out_sum),   32'(e.sum));
            check("out_exact", 32'(out_exact), 32'(e.exact));
            check("out_err",   32'(out_err),   32'(e.err));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (stat_clr) begin
          m_samples = 0;
          m_errs = 0;
          m_max = 0;
        end else if (out_valid && out_ready && e.sum === out_sum) begin
          if (m_samples < 15) m_samples++;
          if (e.err != 9'd0 && m_errs < 15) m_errs++;
          if (int'(e.err) > m_max) m_max = int'(e.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    int   acc;
    int   j;
    vectors = 0;
    miscompares = 0;
    //            a      b      k      sum      exact    err
    vt[0] = '{8'h0F, 8'h01, 4'd0,  9'h010, 9'h010, 9'h000};
    vt[1] = '{8'h0F, 8'h01, 4'd4,  9'h00F, 9'h010, 9'h001};
    vt[2] = '{8'hFF, 8'hFF, 4'd8,  9'h1FF, 9'h1FE, 9'h001};
    vt[3] = '{8'hFF, 8'hFF, 4'd15, 9'h1FF, 9'h1FE, 9'h001};
    vt[4] = '{8'h35, 8'h1B, 4'd3,  9'h04F, 9'h050, 9'h001};
    vt[5] = '{8'h80, 8'h80, 4'd0,  9'h100, 9'h100, 9'h000};
    vt[6] = '{8'hAA, 8'h55, 4'd8,  9'h0FF, 9'h0FF, 9'h000};
    vt[7] = '{8'h0C, 8'h04, 4'd3,  9'h014, 9'h010, 9'h004};
    vt[8] = '{8'h18, 8'h10, 4'd5,  9'h038, 9'h028, 9'h010};
    vt[9] = '{8'h08, 8'h08, 4'd4,  9'h018, 9'h010, 9'h008};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    in_k = 4'd0;
    out_ready = 1'b1;
    stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_exact", 32'(out_exact), 32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_samples",   32'(stat_samples), 32'd0);
    check("rst_errs",      32'(stat_errs),    32'd0);
    check("rst_max_err",   32'(stat_max_err), 32'd0);

    // Exact case and two-cycle latency.
    @(posedge clk);
    #1;
    send(0);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();
    send(1);
    drain();
    check("k4_samples", 32'(stat_samples), 32'd2);
    check("k4_errs",    32'(stat_errs),    32'd1);
    check("k4_max_err", 32'(stat_max_err), 32'd1);

    // Back-to-back stream of the remaining vectors.
    for (int i = 2; i < 10; i++) send(i);
    drain();
    check("stream_samples", 32'(stat_samples), 32'd10);
    check("stream_errs",    32'(stat_errs),    32'd7);
    check("stream_max_err", 32'(stat_max_err), 32'd16);

    // Clear coinciding with a transfer.
    send(8);
    @(posedge clk);
    #1;
    check("clr_coincide_valid", 32'(out_valid), 32'd1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr_samples", 32'(stat_samples), 32'd0);
    check("clr_errs",    32'(stat_errs),    32'd0);
    check("clr_max_err", 32'(stat_max_err), 32'd0);
    check("clr_queue",   32'(exp_q.size()), 32'd0);

    // Backpressure: continuous input while the consumer stalls.
    out_ready = 1'b0;
    acc = 0;
    j = 0;
    for (int c = 0; c < 5; c++) begin
      drive(j);
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        push(j);
        j++;
        acc++;
      end
    end
    check("bp_accepts",  32'(acc),      32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      send(j % 10);
      j++;
    end
    drain();
    check("sat_samples", 32'(stat_samples), 32'd15);
    check_stats("sat");

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send(2);
    send(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(out_valid),    32'd0);
    check("mid_rst_samples", 32'(stat_samples), 32'd0);
    check("mid_rst_max_err", 32'(stat_max_err), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready),     32'd1);
    check("post_rst_errs",     32'(stat_errs),    32'd0);
    send(4);
    drain();
    check("post_rst_samples", 32'(stat_samples), 32'd1);
    check("post_rst_max_err", 32'(stat_max_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
